// File: rtl/vdp_vram_host_write_queue_pkg.sv
// Shared VRAM write-path constants and the queued entry format.
package vdp_vram_host_write_queue_pkg;

    localparam int VRAM_WORD_ADDR_W = 15;
    localparam int VRAM_BANK_ADDR_W = 14;
    localparam int VRAM_DATA_W      = 16;

    localparam logic [1:0] VRAM_MASK_EVEN = 2'b01;
    localparam logic [1:0] VRAM_MASK_ODD  = 2'b10;

    typedef struct packed {
        logic [VRAM_WORD_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0]      data;
    } vram_wr_entry_t;

    // Word address bit0 picks the bank: 0 = even, 1 = odd.
    function automatic logic [1:0] bank_mask(input logic odd_bank);
        return odd_bank ? VRAM_MASK_ODD : VRAM_MASK_EVEN;
    endfunction

endpackage

// File: rtl/vdp_sync_fifo.sv
// Generic show-ahead FIFO. Head is combinational from storage at the read
// pointer. A push while full is taken only if a pop happens the same cycle.
module vdp_sync_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     push_ok_o,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q < CNT_W'(DEPTH)) || do_pop);

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    // Pointer/count registers; clearing them discards all queued entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign push_ok_o = do_push;
    assign head_o    = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/vdp_vram_host_write_queue.sv
// Host write queue feeding the VRAM arbiter host slot. CPU data writes are
// stamped with an auto-incrementing word address and queued; the head is
// presented as {bank mask, bank address, data} and popped by vram_written.
// Optional block fill engine: define VDP_VRAM_FILL_EN.
module vdp_vram_host_write_queue
    import vdp_vram_host_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        host_address_write_en,
    input  logic [VRAM_WORD_ADDR_W-1:0] host_address,
    input  logic                        host_increment_write_en,
    input  logic [7:0]                  host_increment,
    input  logic                        host_data_write_en,
    input  logic [VRAM_DATA_W-1:0]      host_data,
    output logic                        host_ready,
    output logic                        host_overflow,
    input  logic                        host_overflow_clear,
    input  logic                        vram_written,
    output logic [1:0]                  vram_port_write_en_mask,
    output logic [VRAM_BANK_ADDR_W-1:0] vram_write_address_16b,
    output logic [VRAM_DATA_W-1:0]      vram_write_data_16b,
    output logic                        queue_empty,
    input  logic                        fill_start,
    input  logic [VRAM_WORD_ADDR_W-1:0] fill_length,
    output logic                        fill_busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [VRAM_WORD_ADDR_W-1:0] addr_q, addr_d, eff_addr;
    logic [7:0]                  incr_q, incr_d;
    logic                        overflow_q, overflow_d;
    logic                        push_req, push_ok, host_push_req, host_drop;
    logic [VRAM_DATA_W-1:0]      push_data;
    logic [CNT_W-1:0]            fifo_count;
    logic                        fifo_empty;
    logic [$bits(vram_wr_entry_t)-1:0] head_bits;
    vram_wr_entry_t              head, push_entry;
    logic                        fill_busy_w;

`ifdef VDP_VRAM_FILL_EN
    logic                        fill_busy_q, fill_busy_d;
    logic [VRAM_DATA_W-1:0]      fill_data_q, fill_data_d;
    logic [VRAM_DATA_W-1:0]      last_data_q, last_data_d;
    logic [VRAM_WORD_ADDR_W-1:0] fill_rem_q, fill_rem_d;

    assign fill_busy_w   = fill_busy_q;
    assign host_push_req = host_data_write_en && !fill_busy_q;
    assign push_req      = host_push_req || fill_busy_q;
    assign push_data     = fill_busy_q ? fill_data_q : host_data;

    // Fill engine: latch the last accepted host word, then push it once per
    // accepted slot until the remaining length runs out.
    always_comb begin
        last_data_d = last_data_q;
        fill_busy_d = fill_busy_q;
        fill_data_d = fill_data_q;
        fill_rem_d  = fill_rem_q;
        if (host_push_req && push_ok) last_data_d = host_data;
        if (fill_busy_q) begin
            if (push_ok) begin
                fill_rem_d = fill_rem_q - VRAM_WORD_ADDR_W'(1);
                if (fill_rem_q == VRAM_WORD_ADDR_W'(1)) fill_busy_d = 1'b0;
            end
        end else if (fill_start && (fill_length != '0)) begin
            fill_busy_d = 1'b1;
            fill_rem_d  = fill_length;
            fill_data_d = last_data_d;
        end
    end

    // Fill engine registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_busy_q <= 1'b0;
            fill_data_q <= '0;
            last_data_q <= '0;
            fill_rem_q  <= '0;
        end else begin
            fill_busy_q <= fill_busy_d;
            fill_data_q <= fill_data_d;
            last_data_q <= last_data_d;
            fill_rem_q  <= fill_rem_d;
        end
    end
`else
    logic unused_fill;

    assign unused_fill   = ^{fill_start, fill_length};
    assign fill_busy_w   = 1'b0;
    assign host_push_req = host_data_write_en;
    assign push_req      = host_data_write_en;
    assign push_data     = host_data;
`endif

    // A same-cycle address load is the address used by this cycle's push.
    assign eff_addr  = host_address_write_en ? host_address : addr_q;
    assign host_drop = host_data_write_en && !(host_push_req && push_ok);

    assign push_entry.addr = eff_addr;
    assign push_entry.data = push_data;

    // Address/increment/overflow next-state. The increment used is always the
    // registered one, so a same-cycle increment write affects later pushes.
    always_comb begin
        addr_d     = push_ok ? (eff_addr + VRAM_WORD_ADDR_W'(incr_q)) : eff_addr;
        incr_d     = host_increment_write_en ? host_increment : incr_q;
        overflow_d = overflow_q;
        if (host_drop)                overflow_d = 1'b1;
        else if (host_overflow_clear) overflow_d = 1'b0;
    end

    // Host-side configuration and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            incr_q     <= 8'd1;
            overflow_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            incr_q     <= incr_d;
            overflow_q <= overflow_d;
        end
    end

    vdp_sync_fifo #(
        .WIDTH ($bits(vram_wr_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_req),
        .push_data_i (push_entry),
        .pop_i       (vram_written),
        .push_ok_o   (push_ok),
        .head_o      (head_bits),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign head = vram_wr_entry_t'(head_bits);

    // Ready ignores a same-cycle pop so vram_written has no path to it.
    assign host_ready    = (fifo_count < CNT_W'(DEPTH)) && !fill_busy_w;
    assign host_overflow = overflow_q;
    assign fill_busy     = fill_busy_w;
    assign queue_empty   = fifo_empty;

    assign vram_port_write_en_mask = fifo_empty ? 2'b00 : bank_mask(head.addr[0]);
    assign vram_write_address_16b  = fifo_empty ? '0 : head.addr[VRAM_WORD_ADDR_W-1:1];
    assign vram_write_data_16b     = fifo_empty ? '0 : head.data;

endmodule
